msg_bits_pack_ctrl: RTL and testbench

- Sequencer for the decryption message-packing stage.
- Collects the 256 one-bit compressed coefficients of m' from the Compress(.,1) stage as fixed-width beats into a message register.
- Streams the register out as 32 bytes over a valid/ready byte interface: bit i of the message goes to byte i/8, bit position i%8.
- Sits between decompress/compress arithmetic and the G/KDF hash input.

---
 rtl/msg_bits_pack_ctrl.sv | 140 ++++++++++++++
 tb/tb_msg_bits_pack_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_bits_pack_ctrl.sv
// Message-packing sequencer: gathers 1-bit coefficients into a message register and streams it as bytes.
// Optional XOR checksum output is enabled with `define MSG_PACK_CKSUM_EN.
module msg_bits_pack_ctrl #(
   parameter int MSG_BITS = 256,
   parameter int IN_W = 16,
   localparam int MSG_BYTES = MSG_BITS / 8
) (
`ifdef MSG_PACK_CKSUM_EN
   output logic [7:0] cksum,
`endif
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   input  logic in_valid,
   output logic in_ready,
   input  logic [IN_W-1:0] in_bits,
   output logic out_valid,
   input  logic out_ready,
   output logic [7:0] out_byte,
   output logic [$clog2(MSG_BYTES)-1:0] out_idx,
   output logic out_last
);

   localparam int BEATS = MSG_BITS / IN_W;
   localparam int BW = $clog2(BEATS);
   localparam int YW = $clog2(MSG_BYTES);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [YW-1:0] LAST_BYTE = YW'(MSG_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [YW-1:0] byte_q, byte_d;
   logic [MSG_BITS-1:0] msg_q, msg_d;
   logic [7:0] cur_byte;
   logic at_last;

   assign cur_byte = msg_q[byte_q*8 +: 8];
   assign at_last  = (byte_q == LAST_BYTE);

`ifdef MSG_PACK_CKSUM_EN
   logic [7:0] cksum_q, cksum_d;
   assign cksum = cksum_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         byte_q  <= '0;
         msg_q   <= '0;
`ifdef MSG_PACK_CKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         byte_q  <= byte_d;
         msg_q   <= msg_d;
`ifdef MSG_PACK_CKSUM_EN
         cksum_q <= cksum_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      byte_d    = byte_q;
      msg_d     = msg_q;
      busy      = 1'b0;
      done      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_byte  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
`ifdef MSG_PACK_CKSUM_EN
      cksum_d   = cksum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
               beat_d  = '0;
               byte_d  = '0;
`ifdef MSG_PACK_CKSUM_EN
               cksum_d = '0;
`endif
            end
         end
         S_COLLECT: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               msg_d[beat_q*IN_W +: IN_W] = in_bits;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_DRAIN;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_byte  = cur_byte;
            out_idx   = byte_q;
            out_last  = at_last;
            if (out_ready) begin
`ifdef MSG_PACK_CKSUM_EN
               cksum_d = cksum_q ^ cur_byte;
`endif
               // counter holds at the final index rather than wrapping
               if (at_last) begin
                  state_d = S_DONE;
               end else begin
                  byte_d = byte_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_msg_bits_pack_ctrl.sv
// Self-checking bench for msg_bits_pack_ctrl: directed operations against a
// message-level byte model, plus literal byte expectations.
module tb_msg_bits_pack_ctrl;

   logic clk = 1'b0;
   logic rst, start, in_valid, out_ready;
   logic busy, done, in_ready, out_valid, out_last;
   logic [15:0] in_bits;
   logic [7:0] out_byte;
   logic [4:0] out_idx;
`ifdef MSG_PACK_CKSUM_EN
   logic [7:0] cksum;
`endif

   msg_bits_pack_ctrl dut (
`ifdef MSG_PACK_CKSUM_EN
      .cksum(cksum),
`endif
      .clk(clk),
      .rst(rst),
      .start(start),
      .busy(busy),
      .done(done),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_bits(in_bits),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_byte(out_byte),
      .out_idx(out_idx),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [255:0] exp_msg;
   int exp_idx, hs_cnt, ov_cyc, done_cnt;
   bit pend_done, stalled;
   logic [7:0] prev_byte;
   logic [4:0] prev_idx;
   logic [7:0] got [32];
   logic [15:0] beats [16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      if (pend_done) begin
         chk("done_pulse", 32'(done), 1);
         chk("done_busy", 32'(busy), 0);
         chk("done_out_valid", 32'(out_valid), 0);
         pend_done = 0;
      end else if (done) begin
         chk("spurious_done", 32'(done), 0);
      end
      if (done) done_cnt++;
      if (out_valid) begin
         ov_cyc++;
         if (stalled) begin
            chk("stall_byte", 32'(out_byte), 32'(prev_byte));
            chk("stall_idx", 32'(out_idx), 32'(prev_idx));
         end
         chk("byte", 32'(out_byte), 32'(exp_msg[exp_idx*8 +: 8]));
         chk("idx", 32'(out_idx), exp_idx);
         chk("last", 32'(out_last), 32'(exp_idx == 31));
         chk("in_ready_drain", 32'(in_ready), 0);
         if (out_ready) begin
            got[exp_idx] = out_byte;
            hs_cnt++;
            if (exp_idx == 31) pend_done = 1;
            exp_idx++;
            stalled = 0;
         end else begin
            stalled = 1;
            prev_byte = out_byte;
            prev_idx = out_idx;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input bit gap, input int stall_at,
                         input int stall_len, input bit poke,
                         input int rst_at);
      int k, g, sn, d0;
      logic [7:0] x;
      for (int i = 0; i < 16; i++) exp_msg[i*16 +: 16] = beats[i];
      exp_idx = 0;
      hs_cnt = 0;
      ov_cyc = 0;
      stalled = 0;
      pend_done = 0;
      d0 = done_cnt;
      start = 1;
      in_valid = 0;
      tick();
      start = 0;
      chk("busy_after_start", 32'(busy), 1);
      chk("in_ready_collect", 32'(in_ready), 1);
      k = 0;
      g = 0;
      while (k < 16 && g < 200) begin
         if (gap && g % 2 == 1) begin
            in_valid = 0;
            in_bits = 16'hFFFF;
         end else begin
            in_valid = 1;
            in_bits = beats[k];
         end
         start = poke && (k == 3);
         if (in_valid && in_ready) k++;
         tick();
         g++;
      end
      chk("collect_bound", 32'(k), 16);
      start = 0;
      in_valid = gap;
      in_bits = 16'hDEAD;
      chk("first_byte_latency", 32'(out_valid), 1);
      chk("in_ready_drop", 32'(in_ready), 0);
      g = 0;
      sn = 0;
      while (done_cnt == d0 && g < 400) begin
         if (rst_at >= 0 && exp_idx == rst_at) begin
            out_ready = 0;
            rst = 1;
            tick();
            rst = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            stalled = 0;
            pend_done = 0;
            in_valid = 0;
            return;
         end
         if (exp_idx == stall_at && sn < stall_len) begin
            out_ready = 0;
            sn++;
         end else begin
            out_ready = 1;
         end
         start = poke && (exp_idx == 5);
         tick();
         g++;
      end
      start = 0;
      in_valid = 0;
      chk("done_bound", 32'(done_cnt - d0), 1);
      chk("handshakes", 32'(hs_cnt), 32);
      chk("drain_cycles", 32'(ov_cyc), 32 + (stall_at >= 0 ? stall_len : 0));
      chk("idle_busy", 32'(busy), 0);
`ifdef MSG_PACK_CKSUM_EN
      x = 8'h00;
      for (int i = 0; i < 32; i++) x ^= exp_msg[i*8 +: 8];
      chk("cksum", 32'(cksum), 32'(x));
`else
      x = 8'h00;
`endif
      tick();
      chk("no_second_done", 32'(done_cnt - d0), 1);
   endtask

   initial begin
      rst = 1;
      start = 0;
      in_valid = 0;
      in_bits = '0;
      out_ready = 0;
      done_cnt = 0;
      exp_idx = 0;
      pend_done = 0;
      stalled = 0;
      exp_msg = '0;
      repeat (3) tick();
      rst = 0;
      in_valid = 1;
      in_bits = 16'hBEEF;
      tick();
      chk("rst_busy0", 32'(busy), 0);
      chk("rst_done0", 32'(done), 0);
      chk("rst_in_ready0", 32'(in_ready), 0);
      chk("rst_out_valid0", 32'(out_valid), 0);
      chk("rst_out_last0", 32'(out_last), 0);
      chk("rst_out_idx0", 32'(out_idx), 0);
      chk("rst_out_byte0", 32'(out_byte), 0);
      in_valid = 0;

      for (int i = 0; i < 16; i++) beats[i] = 16'h0001;
      run_op(0, -1, 0, 0, -1);
      chk("lit_t1_b0", 32'(got[0]), 32'h01);
      chk("lit_t1_b1", 32'(got[1]), 32'h00);
      chk("lit_t1_b30", 32'(got[30]), 32'h01);
      chk("lit_t1_b31", 32'(got[31]), 32'h00);

      for (int i = 0; i < 16; i++) beats[i] = 16'h0000;
      beats[0] = 16'hA55A;
      run_op(0, -1, 0, 0, -1);
      chk("lit_t2_b0", 32'(got[0]), 32'h5A);
      chk("lit_t2_b1", 32'(got[1]), 32'hA5);
      chk("lit_t2_b2", 32'(got[2]), 32'h00);

      for (int i = 0; i < 16; i++) beats[i] = 16'(i);
      run_op(1, -1, 0, 0, -1);
      chk("lit_t3_b6", 32'(got[6]), 32'h03);
      chk("lit_t3_b7", 32'(got[7]), 32'h00);
      chk("lit_t3_b30", 32'(got[30]), 32'h0F);

      for (int i = 0; i < 16; i++) beats[i] = 16'h1234 + 16'(i * 16'h0101);
      run_op(0, 7, 5, 0, -1);
      chk("lit_t4_b0", 32'(got[0]), 32'h34);
      chk("lit_t4_b7", 32'(got[7]), 32'h15);

      for (int i = 0; i < 16; i++) beats[i] = 16'hC3C3 ^ 16'(i);
      run_op(0, -1, 0, 1, -1);
      chk("lit_t5_b2", 32'(got[2]), 32'hC2);
      for (int i = 0; i < 16; i++) beats[i] = 16'h8001;
      run_op(0, -1, 0, 0, -1);
      chk("lit_t5n_b1", 32'(got[1]), 32'h80);

      for (int i = 0; i < 16; i++) beats[i] = 16'hFFFF;
      run_op(0, -1, 0, 0, 10);
      tick();
      chk("post_rst_idle", 32'(busy), 0);
      for (int i = 0; i < 16; i++) beats[i] = 16'h00F0 + 16'(i);
      run_op(0, -1, 0, 0, -1);
      chk("lit_t6_b0", 32'(got[0]), 32'hF0);
      chk("lit_t6_b1", 32'(got[1]), 32'h00);
      chk("lit_t6_b2", 32'(got[2]), 32'hF1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
